fpmul_pipe: RTL

Parametrised, fully pipelined IEEE-754-style floating-point multiplier, the next generation of the fixed FP32 `FPmul`/`FPmul_sc` pair. Exponent and mantissa widths are set per instance, so one RTL source serves FP32, FP16 and BFP16 lanes in `smul`/`smac`. The pipeline accepts one operand pair per cycle under a global clock enable, carries a valid bit and a tag alongside the data, rounds to nearest-even, and reports exception flags per result.

---
 rtl/fpmul_pipe.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/fpmul_pipe.sv
// fpmul_pipe: three-stage IEEE-754-style floating-point multiplier.
// Exponent and mantissa widths are parameters. Denormal inputs and results
// are flushed to zero. Rounding is to nearest-even. A valid bit and a tag
// travel with each operation.
//
// Handshake: there is no ready signal. An operation is accepted on every
// rising edge where ce=1 and in_valid=1. The matching result appears with
// out_valid=1 after exactly three ce=1 edges. While ce=0 every register
// holds, so a presented result stays on the outputs until ce returns high.
// sclr clears all valid bits and the output registers whatever ce is.
module fpmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       sclr,
    input  logic                       ce,
    input  logic                       in_valid,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    output logic [EXP_W+MAN_W:0]       z,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       flag_ovf,
    output logic                       flag_unf,
    output logic                       flag_inv,
    output logic                       flag_inx
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * MAN_W + 2;
    localparam int EW     = EXP_W + 2;

    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    // Special-case class resolved once in stage 1 and carried to the output.
    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_NAN  = 2'd1,
        CLS_INF  = 2'd2,
        CLS_ZERO = 2'd3
    } cls_t;

    // ---------------- stage 1: unpack and classify ----------------
    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   ma, mb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_snan, b_snan;
    cls_t               c1_cls;
    logic               c1_inv;
    logic signed [EW-1:0] c1_exp;

    assign {sa, ea, ma} = a;
    assign {sb, eb, mb} = b;

    // A zero exponent covers both true zeros and denormals, which are flushed.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_nan  = (ea == EXP_ONES) && (ma != '0);
    assign b_nan  = (eb == EXP_ONES) && (mb != '0);
    assign a_inf  = (ea == EXP_ONES) && (ma == '0);
    assign b_inf  = (eb == EXP_ONES) && (mb == '0);
    assign a_snan = a_nan && !ma[MAN_W-1];
    assign b_snan = b_nan && !mb[MAN_W-1];

    assign c1_exp = signed'({2'b00, ea}) + signed'({2'b00, eb}) - BIAS;

    // Resolve special-case priority: NaN/invalid, then inf, then zero.
    always_comb begin
        c1_cls = CLS_NORM;
        c1_inv = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            c1_cls = CLS_NAN;
            c1_inv = (a_inf && b_zero) || (a_zero && b_inf) || a_snan || b_snan;
        end else if (a_inf || b_inf) begin
            c1_cls = CLS_INF;
        end else if (a_zero || b_zero) begin
            c1_cls = CLS_ZERO;
        end
    end

    logic [TAG_W-1:0]     s1_tag, s2_tag;
    logic                 s1_valid, s2_valid;
    logic                 s1_sign, s2_sign;
    logic signed [EW-1:0] s1_exp, s2_exp;
    logic [SIG_W-1:0]     s1_siga, s1_sigb;
    cls_t                 s1_cls, s2_cls;
    logic                 s1_inv, s2_inv;
    logic [PROD_W-1:0]    s2_prod;

    // Valid bits: cleared by sclr, advanced on every enabled edge.
    always_ff @(posedge clk) begin
        if (sclr) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
        end
    end

    // Stage 1 and 2 data registers; contents are don't-care when not valid.
    always_ff @(posedge clk) begin
        if (ce) begin
            s1_tag  <= in_tag;
            s1_sign <= sa ^ sb;
            s1_exp  <= c1_exp;
            s1_siga <= {1'b1, ma};
            s1_sigb <= {1'b1, mb};
            s1_cls  <= c1_cls;
            s1_inv  <= c1_inv;

            s2_tag  <= s1_tag;
            s2_sign <= s1_sign;
            s2_exp  <= s1_exp;
            s2_prod <= PROD_W'(s1_siga) * PROD_W'(s1_sigb);
            s2_cls  <= s1_cls;
            s2_inv  <= s1_inv;
        end
    end

    // ---------------- stage 3: normalise, round, pack ----------------
    logic [PROD_W-2:0]    norm;
    logic [MAN_W-1:0]     mant;
    logic                 guard, sticky, round_up;
    logic [MAN_W:0]       mant_r;
    logic signed [EW-1:0] exp_f;
    logic [W-1:0]         r_z;
    logic                 r_ovf, r_unf, r_inv, r_inx;

    // Drop the leading one so the kept mantissa always sits at the top of norm.
    always_comb begin
        norm     = s2_prod[PROD_W-1] ? s2_prod[PROD_W-2:0]
                                     : {s2_prod[PROD_W-3:0], 1'b0};
        mant     = norm[PROD_W-2 -: MAN_W];
        guard    = norm[MAN_W];
        sticky   = |norm[MAN_W-1:0];
        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + (MAN_W + 1)'(round_up);
        // A rounding carry leaves the mantissa field all zeros; only the exponent moves.
        exp_f    = s2_exp + signed'(EW'(s2_prod[PROD_W-1])) + signed'(EW'(mant_r[MAN_W]));
    end

    // Select the packed result and flags by special-case priority.
    always_comb begin
        r_z   = '0;
        r_ovf = 1'b0;
        r_unf = 1'b0;
        r_inv = 1'b0;
        r_inx = 1'b0;
        case (s2_cls)
            CLS_NAN: begin
                r_z   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
                r_inv = s2_inv;
            end
            CLS_INF: begin
                r_z = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            end
            CLS_ZERO: begin
                r_z = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
            end
            default: begin
                if (exp_f >= EXP_MAX) begin
                    r_z   = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
                    r_ovf = 1'b1;
                    r_inx = 1'b1;
                end else if (exp_f <= EXP_ZERO) begin
                    r_z   = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
                    r_unf = 1'b1;
                    r_inx = 1'b1;
                end else begin
                    r_z   = {s2_sign, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
                    r_inx = guard | sticky;
                end
            end
        endcase
    end

    // Output registers: reset to zero, otherwise load on every enabled edge.
    always_ff @(posedge clk) begin
        if (sclr) begin
            z        <= '0;
            out_tag  <= '0;
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_inv <= 1'b0;
            flag_inx <= 1'b0;
        end else if (ce) begin
            z        <= r_z;
            out_tag  <= s2_tag;
            flag_ovf <= r_ovf;
            flag_unf <= r_unf;
            flag_inv <= r_inv;
            flag_inx <= r_inx;
        end
    end

endmodule
